// File: rtl/fifo_stream_ctrl_pkg.sv
// fifo_stream_ctrl_pkg: controller states, default timing constants and output buffer sizing
package fifo_stream_ctrl_pkg;
  typedef enum logic [1:0] {RESET, FRST, GUARD, RUN} state_e;
  localparam int DEF_RST_CYCLES = 5;
  localparam int DEF_GUARD_CYCLES = 4;
  function automatic int obuf_depth(input int rd_lat);
    return rd_lat + 1;
  endfunction
endpackage

// File: rtl/fifo_stream_ctrl_if.sv
// fifo_stream_ctrl_if: valid/ready/data stream with producer (master) and consumer (slave) views
interface fifo_stream_ctrl_if #(parameter int WIDTH = 9);
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, data, input ready);
  modport slave (input valid, data, output ready);
endinterface

// File: rtl/fifo_stream_obuf.sv
// fifo_stream_obuf: circular output buffer that absorbs the FIFO primitive read latency
module fifo_stream_obuf import fifo_stream_ctrl_pkg::*; #(
  parameter int WIDTH = 9,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             cap,
  output logic [1:0]       occ
);
  localparam int DEPTH = obuf_depth(RD_LAT);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [1:0] occ_q, occ_d;
  logic [RD_LAT-1:0] vsr_q, vsr_d;
  logic pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign valid = occ_q != 2'd0;
  assign dout = mem_q[rp_q];
  assign cap = vsr_q[RD_LAT-1];
  assign occ = occ_q;
  assign pop = valid & ready;
  always_comb begin
    mem_d = mem_q;
    if (cap) mem_d[wp_q] = din;
    vsr_d = clr ? '0 : RD_LAT'({vsr_q, issue});
    wp_d = clr ? '0 : cap ? nxt(wp_q) : wp_q;
    rp_d = clr ? '0 : pop ? nxt(rp_q) : rp_q;
    occ_d = clr ? '0 : occ_q + 2'(cap) - 2'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
      vsr_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      occ_q <= occ_d;
      vsr_q <= vsr_d;
    end
endmodule

// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: sequences the FIFO primitive reset/guard and bridges wr_en/rd_en to valid/ready streams
module fifo_stream_ctrl import fifo_stream_ctrl_pkg::*; #(
  parameter int WIDTH = 9,
  parameter int RD_LAT = 1,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  fifo_stream_ctrl_if.slave  s,
  fifo_stream_ctrl_if.master m,
  output logic             fifo_rst,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] fifo_din,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic             fifo_rderr,
  input  logic             fifo_wrerr,
  output logic             busy,
  output logic             err
);
  localparam int DEPTH = obuf_depth(RD_LAT);
  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] infl_q, infl_d, occ;
  logic err_q, err_d, run, clr, cap;
  assign run = state_q == RUN;
  assign clr = ~run | flush;
  assign busy = ~run;
  assign err = err_q;
  assign fifo_rst = state_q == RESET || state_q == FRST;
  assign s.ready = run & ~fifo_full;
  assign fifo_wr_en = s.valid & s.ready;
  assign fifo_din = s.data;
  // a pop in this cycle frees its slot now, so full-rate streaming has no bubbles
  assign fifo_rd_en = run & ~fifo_empty &
                      (3'(occ) + 3'(infl_q) - 3'(m.valid & m.ready) < 3'(DEPTH));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 8'd1;
    unique case (state_q)
      RESET: begin state_d = FRST; cnt_d = '0; end
      FRST: if (cnt_q == 8'(RST_CYCLES - 1)) begin state_d = GUARD; cnt_d = '0; end
      GUARD: if (cnt_q == 8'(GUARD_CYCLES - 1)) begin state_d = RUN; cnt_d = '0; end
      RUN: begin cnt_d = '0; state_d = flush ? FRST : RUN; end
    endcase
    infl_d = clr ? '0 : infl_q + 2'(fifo_rd_en) - 2'(cap);
    err_d = err_q | (run & (fifo_rderr | fifo_wrerr));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RESET;
      cnt_q <= '0;
      infl_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      infl_q <= infl_d;
      err_q <= err_d;
    end
  fifo_stream_obuf #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_obuf (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .issue(fifo_rd_en),
    .din(fifo_dout),
    .ready(m.ready),
    .valid(m.valid),
    .dout(m.data),
    .cap(cap),
    .occ(occ)
  );
endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// tb_fifo_stream_ctrl: directed checks of RD_LAT=1 (g=0) and RD_LAT=2 (g=1) controllers driven in lockstep
module tb_fifo_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n, flush, s_valid, m_ready, force_full, wrerr;
  logic [8:0] s_data;
  logic [1:0] s_ready_a, m_valid_a, f_rst_a, wr_en_a, rd_en_a, busy_a, err_a;
  logic [8:0] m_data_a [2];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    fifo_stream_ctrl_if #(.WIDTH(9)) s_if ();
    fifo_stream_ctrl_if #(.WIDTH(9)) m_if ();
    logic [8:0] din, dout;
    logic empty, full;
    logic [8:0] mem [16];
    logic [8:0] pipe [2];
    logic [3:0] wp, rp;
    logic [4:0] cnt;
    assign s_if.valid = s_valid;
    assign s_if.data = s_data;
    assign s_ready_a[g] = s_if.ready;
    assign m_if.ready = m_ready;
    assign m_valid_a[g] = m_if.valid;
    assign m_data_a[g] = m_if.data;
    fifo_stream_ctrl #(.WIDTH(9), .RD_LAT(g + 1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .s(s_if), .m(m_if),
      .fifo_rst(f_rst_a[g]), .fifo_wr_en(wr_en_a[g]), .fifo_rd_en(rd_en_a[g]),
      .fifo_din(din), .fifo_dout(dout), .fifo_full(full), .fifo_empty(empty),
      .fifo_rderr(1'b0), .fifo_wrerr(wrerr), .busy(busy_a[g]), .err(err_a[g]));
    // behavioural FIFO wrapper: empty follows the registered count, dout lags rd_en by g+1 edges
    always @(posedge clk) begin
      if (f_rst_a[g]) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (wr_en_a[g]) begin mem[wp] <= din; wp <= wp + 4'd1; end
        if (rd_en_a[g]) begin pipe[0] <= mem[rp]; rp <= rp + 4'd1; end
        cnt <= cnt + 5'(wr_en_a[g]) - 5'(rd_en_a[g]);
      end
      pipe[1] <= pipe[0];
    end
    assign dout = pipe[g];
    assign empty = cnt == 5'd0;
    assign full = force_full | (cnt == 5'd16);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; force_full = 1'b0; wrerr = 1'b0;
    repeat (3) cyc();
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({f_rst_a[g], wr_en_a[g], rd_en_a[g], s_ready_a[g], m_valid_a[g], busy_a[g], err_a[g]} !== 7'b1000010) begin
        bad++;
        $display("FAIL reset_flags g=%0d got=%b exp=1000010", g,
                 {f_rst_a[g], wr_en_a[g], rd_en_a[g], s_ready_a[g], m_valid_a[g], busy_a[g], err_a[g]});
      end
      total++;
      if (m_data_a[g] !== 9'h000) begin bad++; $display("FAIL reset_m_data g=%0d got=%h exp=000", g, m_data_a[g]); end
    end
    rst_n = 1'b1; s_valid = 1'b1; s_data = 9'h055; wrerr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      for (int g = 0; g < 2; g++) begin
        total++;
        if (f_rst_a[g] !== (k <= 5)) begin bad++; $display("FAIL seq_fifo_rst g=%0d edge=%0d got=%b exp=%b", g, k, f_rst_a[g], k <= 5); end
        total++;
        if (busy_a[g] !== (k <= 9)) begin bad++; $display("FAIL seq_busy g=%0d edge=%0d got=%b exp=%b", g, k, busy_a[g], k <= 9); end
        total++;
        if ({s_ready_a[g], wr_en_a[g]} !== {2{k >= 10}}) begin bad++; $display("FAIL seq_s_ready_wr g=%0d edge=%0d got=%b%b exp=%b", g, k, s_ready_a[g], wr_en_a[g], k >= 10); end
        total++;
        if ({rd_en_a[g], err_a[g]} !== 2'b00) begin bad++; $display("FAIL seq_rd_err g=%0d edge=%0d got=%b%b exp=00", g, k, rd_en_a[g], err_a[g]); end
      end
    end
    s_valid = 1'b0; wrerr = 1'b0;
  endtask

  task automatic test_stream();
    logic ev;
    m_ready = 1'b1; s_valid = 1'b1; s_data = 9'h011;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      s_valid = k < 3;
      s_data = 9'(17 * (k + 1));
      #1;
      for (int g = 0; g < 2; g++) begin
        ev = k >= 3 + g && k <= 5 + g;
        total++;
        if (m_valid_a[g] !== ev) begin bad++; $display("FAIL stream_valid g=%0d edge=%0d got=%b exp=%b", g, k, m_valid_a[g], ev); end
        if (ev) begin
          total++;
          if (m_data_a[g] !== 9'(17 * (k - 2 - g))) begin bad++; $display("FAIL stream_data g=%0d edge=%0d got=%h exp=%h", g, k, m_data_a[g], 9'(17 * (k - 2 - g))); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int rds [2];
    int n [2];
    logic [8:0] got [2][8];
    rds = '{0, 0}; n = '{0, 0};
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = i < 8;
      s_data = 9'h101 + 9'(i);
      #1;
      for (int g = 0; g < 2; g++) if (rd_en_a[g]) rds[g]++;
      cyc();
    end
    for (int g = 0; g < 2; g++) begin
      total++;
      if (rds[g] != g + 2) begin bad++; $display("FAIL bp_rd_pulses g=%0d got=%0d exp=%0d", g, rds[g], g + 2); end
      total++;
      if ({m_valid_a[g], m_data_a[g]} !== {1'b1, 9'h101}) begin bad++; $display("FAIL bp_hold g=%0d got=%b/%h exp=1/101", g, m_valid_a[g], m_data_a[g]); end
    end
    m_ready = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      for (int g = 0; g < 2; g++)
        if (m_valid_a[g]) begin
          if (n[g] < 8) got[g][n[g]] = m_data_a[g];
          n[g]++;
        end
      cyc();
    end
    for (int g = 0; g < 2; g++) begin
      total++;
      if (n[g] != 8) begin bad++; $display("FAIL bp_count g=%0d got=%0d exp=8", g, n[g]); end
      for (int i = 0; i < 8 && i < n[g]; i++) begin
        total++;
        if (got[g][i] !== 9'h101 + 9'(i)) begin bad++; $display("FAIL bp_order g=%0d idx=%0d got=%h exp=%h", g, i, got[g][i], 9'h101 + 9'(i)); end
      end
    end
  endtask

  task automatic test_full();
    force_full = 1'b1; s_valid = 1'b1; s_data = 9'h1EE;
    #1;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({s_ready_a[g], wr_en_a[g]} !== 2'b00) begin bad++; $display("FAIL full_block g=%0d got=%b%b exp=00", g, s_ready_a[g], wr_en_a[g]); end
    end
    cyc();
    force_full = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({s_ready_a[g], wr_en_a[g]} !== 2'b11) begin bad++; $display("FAIL full_recover g=%0d got=%b%b exp=11", g, s_ready_a[g], wr_en_a[g]); end
    end
    s_valid = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    int n [2];
    logic [8:0] first [2];
    n = '{0, 0};
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = i < 3;
      s_data = 9'h0A1 + 9'(i);
      cyc();
    end
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({m_valid_a[g], m_data_a[g]} !== {1'b1, 9'h0A1}) begin bad++; $display("FAIL flush_pre g=%0d got=%b/%h exp=1/0a1", g, m_valid_a[g], m_data_a[g]); end
    end
    flush = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      flush = 1'b0;
      for (int g = 0; g < 2; g++) begin
        total++;
        if (m_valid_a[g] !== 1'b0) begin bad++; $display("FAIL flush_m_valid g=%0d edge=%0d got=%b exp=0", g, j, m_valid_a[g]); end
        total++;
        if ({f_rst_a[g], busy_a[g]} !== {j <= 5, j <= 9}) begin bad++; $display("FAIL flush_seq g=%0d edge=%0d got=%b%b exp=%b%b", g, j, f_rst_a[g], busy_a[g], j <= 5, j <= 9); end
      end
    end
    m_ready = 1'b1; s_valid = 1'b1; s_data = 9'h0B7;
    cyc();
    s_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      for (int g = 0; g < 2; g++)
        if (m_valid_a[g]) begin
          if (n[g] == 0) first[g] = m_data_a[g];
          n[g]++;
        end
    end
    for (int g = 0; g < 2; g++) begin
      total++;
      if (n[g] != 1) begin bad++; $display("FAIL flush_word_count g=%0d got=%0d exp=1", g, n[g]); end
      if (n[g] > 0) begin
        total++;
        if (first[g] !== 9'h0B7) begin bad++; $display("FAIL flush_stale g=%0d got=%h exp=0b7", g, first[g]); end
      end
    end
  endtask

  task automatic test_err();
    for (int g = 0; g < 2; g++) begin
      total++;
      if (err_a[g] !== 1'b0) begin bad++; $display("FAIL err_clean g=%0d got=%b exp=0", g, err_a[g]); end
    end
    wrerr = 1'b1;
    cyc();
    wrerr = 1'b0;
    for (int g = 0; g < 2; g++) begin
      total++;
      if (err_a[g] !== 1'b1) begin bad++; $display("FAIL err_set g=%0d got=%b exp=1", g, err_a[g]); end
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (12) cyc();
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({err_a[g], busy_a[g]} !== 2'b10) begin bad++; $display("FAIL err_after_flush g=%0d got=%b%b exp=10", g, err_a[g], busy_a[g]); end
    end
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({err_a[g], f_rst_a[g], busy_a[g]} !== 3'b011) begin bad++; $display("FAIL err_async_rst g=%0d got=%b%b%b exp=011", g, err_a[g], f_rst_a[g], busy_a[g]); end
    end
    repeat (2) cyc();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full();
    test_flush();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_stream_ctrl.md
# fifo_stream_ctrl

Single-clock controller that owns one 18Kb block-RAM FIFO primitive instance in synchronous mode (the team's FIFO wrapper, non-first-word-fall-through). It sequences the primitive's reset and guard interval and converts its raw write-enable/read-enable interface into valid/ready streams. Its output buffer hides the primitive's fixed read latency. It sits between a producer/consumer pair and the FIFO wrapper, and it is the only driver of the wrapper's rst, wr_en and rd_en.

## Interface
- WIDTH, 9: data width; same value as the attached FIFO wrapper.
- RD_LAT, 1: cycles from fifo_rd_en to valid fifo_dout; legal values 1 and 2.
- RST_CYCLES, 5: cycles fifo_rst is held high.
- GUARD_CYCLES, 4: cycles after fifo_rst falls during which fifo_wr_en and fifo_rd_en stay low.

Ports:
- clk  in  1  single clock; drives both primitive clocks.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous request to restart the reset sequence.
- s_valid  in  1  producer word valid.
- s_ready  out  1  producer may transfer.
- s_data  in  WIDTH  producer word.
- m_valid  out  1  consumer word valid.
- m_ready  in  1  consumer accepts.
- m_data  out  WIDTH  consumer word.
- fifo_rst  out  1  to wrapper rst.
- fifo_wr_en  out  1  to wrapper wr_en.
- fifo_rd_en  out  1  to wrapper rd_en.
- fifo_din  out  WIDTH  to wrapper din.
- fifo_dout  in  WIDTH  from wrapper dout.
- fifo_full, fifo_empty  in  1 each  wrapper flags.
- fifo_rderr, fifo_wrerr  in  1 each  wrapper error strobes.
- busy  out  1  high whenever the controller is not in RUN.
- err  out  1  sticky; set by fifo_rderr or fifo_wrerr while in RUN.

## Operation
- States:
  - RESET: entered asynchronously while rst_n is low.
  - FRST: fifo_rst is high; a counter counts RST_CYCLES.
  - GUARD: counts GUARD_CYCLES.
  - RUN: normal operation.
- Transitions: RESET→FRST on the first clk edge with rst_n high; FRST→GUARD after RST_CYCLES; GUARD→RUN after GUARD_CYCLES.
- flush has effect only in RUN. A flush in RUN sends the controller to FRST on the next edge.
- Write path: s_ready = RUN & ~fifo_full. fifo_wr_en = s_valid & s_ready. fifo_din = s_data, combinational.
- Read path:
  - The output buffer holds DEPTH = RD_LAT+1 entries as a circular buffer.
  - inflight = number of reads issued whose data has not yet returned.
  - fifo_rd_en = RUN & ~fifo_empty & (occupancy + inflight < DEPTH).
  - Returned data is captured into the buffer RD_LAT cycles after the read is issued, using a RD_LAT-deep valid shift register.
- m_valid = occupancy != 0. m_data = head entry. A pop occurs on m_valid & m_ready.
- Counters:
  - occupancy and inflight are each 2 bits wide; pointers wrap modulo DEPTH.
  - A capture and a pop in the same cycle leave occupancy unchanged.
  - inflight may reach DEPTH but never exceed it.
- Entering FRST, by reset or flush, clears the buffer, the inflight count, the valid shift register and both pointers. Returning data already in flight is discarded.
- err is cleared only by rst_n low; flush does not clear it.

## Timing
- Reset values: fifo_rst=1, fifo_wr_en=0, fifo_rd_en=0, s_ready=0, m_valid=0, m_data=0, busy=1, err=0.
- fifo_rst is asserted asynchronously with rst_n low and deasserts only when FRST ends.
- After rst_n rises, fifo_rst stays high for RST_CYCLES edges; GUARD_CYCLES edges later, RUN begins.
- First possible s_ready is RST_CYCLES+GUARD_CYCLES+1 edges after rst_n rises, which is 10 with the defaults.
- Latency from write to m_valid: the write edge, then fifo_empty deasserting (primitive latency), then fifo_rd_en, then RD_LAT, then m_valid on the next cycle.
- m_ready held high with the FIFO non-empty gives one word per cycle sustained, with no bubbles, for both RD_LAT values.
- m_ready low: at most DEPTH reads are outstanding or buffered. No entry is overwritten; m_data stays stable while m_valid & ~m_ready.
- flush and a write in the same cycle: the write is accepted, then discarded by the primitive reset.

## Structure
- Package fifo_stream_ctrl_pkg holds:
  - the state enum (RESET, FRST, GUARD, RUN);
  - default constants for RST_CYCLES and GUARD_CYCLES;
  - a function computing DEPTH from RD_LAT.
- One sub-module, fifo_stream_obuf, contains the circular output buffer, occupancy counter and valid shift register. The top level keeps the FSM, the counters, the write path and err.

## Test plan
- Reset sequence: release rst_n → fifo_rst high for exactly 5 edges, busy high for 9 edges, s_ready rises on edge 10; no fifo_wr_en or fifo_rd_en before then.
- Streaming: write 0x011, 0x022, 0x033 with m_ready held high → m_data is 0x011, 0x022, 0x033 in order on consecutive cycles, for both RD_LAT=1 and RD_LAT=2.
- Backpressure: 8 words written, m_ready low → fifo_rd_en pulses total exactly DEPTH; m_data holds the first word; releasing m_ready delivers all 8 words in order.
- Full: fifo_full forced high → s_ready=0 and fifo_wr_en=0 that same cycle; both recover when fifo_full drops.
- Flush mid-stream: flush with 2 words buffered and 1 in flight → m_valid=0 on the next cycle, fifo_rst high for 5 cycles, busy high, and no stale word appears afterwards.
- Errors: a fifo_wrerr pulse in RUN → err=1 and it stays 1 through a flush; err returns to 0 only after rst_n goes low.
